// File: rtl/mem_arbiter_if.sv
// Request/grant and memory-side signal bundle for mem_arbiter.
// The arbiter takes the slave view; requesters plus the memory array take the master view.
interface mem_arbiter_if #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 5
);
  logic [1:0]        req;
  logic [1:0]        r_nw;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [WORD_W-1:0] wdata0;
  logic [WORD_W-1:0] wdata1;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic [WORD_W-1:0] rdata;
  logic              mem_cs;
  logic              mem_r_nw;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

`ifdef MEM_WAIT_EN
  logic              mem_ready;

  modport master (
    output req, r_nw, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ready,
    input  gnt, done, rdata, mem_cs, mem_r_nw, mem_addr, mem_wdata
  );

  modport slave (
    input  req, r_nw, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ready,
    output gnt, done, rdata, mem_cs, mem_r_nw, mem_addr, mem_wdata
  );
`else
  modport master (
    output req, r_nw, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt, done, rdata, mem_cs, mem_r_nw, mem_addr, mem_wdata
  );

  modport slave (
    input  req, r_nw, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt, done, rdata, mem_cs, mem_r_nw, mem_addr, mem_wdata
  );
`endif
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-port memory between the CPU (port 0) and loader (port 1).
// Define MEM_WAIT_EN to add mem_ready, which stretches the memory access cycle.
module mem_arbiter #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              win_q, win_d;
  logic              rnw_q, rnw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic              win_sel;
  logic              access_ok;
  logic [1:0]        win_onehot;
  logic              cs;

  // A lone requester always wins; the pointer only breaks ties.
  assign win_sel = (bus.req == 2'b10) ? 1'b1 :
                   (bus.req == 2'b01) ? 1'b0 : ptr_q;

`ifdef MEM_WAIT_EN
  assign access_ok = bus.mem_ready;
`else
  assign access_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    rnw_d   = rnw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          win_d   = win_sel;
          rnw_d   = bus.r_nw[win_sel];
          addr_d  = win_sel ? bus.addr1  : bus.addr0;
          wdata_d = win_sel ? bus.wdata1 : bus.wdata0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (access_ok) begin
          state_d = COMPLETE;
        end
      end
      COMPLETE: begin
        if (rnw_q) begin
          rdata_d = bus.mem_rdata;
        end
        ptr_d   = ~win_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      rnw_q   <= rnw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign win_onehot = win_q ? 2'b10 : 2'b01;
  assign cs         = (state_q == ACCESS);

  assign bus.gnt       = (state_q != IDLE)     ? win_onehot : 2'b00;
  assign bus.done      = (state_q == COMPLETE) ? win_onehot : 2'b00;
  assign bus.mem_cs    = cs;
  assign bus.mem_r_nw  = cs & rnw_q;
  assign bus.mem_addr  = cs ? addr_q  : '0;
  assign bus.mem_wdata = cs ? wdata_q : '0;

  // Memory data only arrives in COMPLETE, so it is forwarded alongside done and
  // captured into rdata_q to hold until the next read.
  assign bus.rdata = (state_q == COMPLETE && rnw_q) ? bus.mem_rdata : rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses, registered memory model, queued expectations.
module tb_mem_arbiter;
  localparam int WORD_W = 8;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic       rnw;
    logic [4:0] addr;
    logic [7:0] wdata;
  } mexp_t;

  typedef struct packed {
    logic [1:0] done;
    logic [7:0] rdata;
  } dexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  mexp_t mq[$];
  dexp_t dq[$];
  mexp_t m_got;
  dexp_t d_got;

  logic [7:0] mem [32];
  logic       ready_now;

  mem_arbiter_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus();

  mem_arbiter #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef MEM_WAIT_EN
  assign ready_now = bus.mem_ready;
`else
  assign ready_now = 1'b1;
`endif

  // Single-port memory: read data appears in the cycle after the accepted CS cycle.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      mem[3]  <= 8'hA5;
      mem[4]  <= 8'h55;
      mem[5]  <= 8'h66;
      mem[6]  <= 8'h77;
      mem[7]  <= 8'hE7;
      mem[8]  <= 8'h88;
      mem[9]  <= 8'h99;
      mem[16] <= 8'hC0;
      mem[17] <= 8'hC1;
      mem[18] <= 8'hC2;
      mem[19] <= 8'hC3;
    end else if (bus.mem_cs && ready_now) begin
      if (bus.mem_r_nw) bus.mem_rdata <= mem[bus.mem_addr];
      else              mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_mem(input logic rnw, input logic [4:0] a, input logic [7:0] wd);
    mexp_t e;
    e.rnw = rnw; e.addr = a; e.wdata = wd;
    mq.push_back(e);
  endtask

  task automatic push_done(input logic [1:0] d, input logic [7:0] rd);
    dexp_t e;
    e.done = d; e.rdata = rd;
    dq.push_back(e);
  endtask

  // Monitor: protocol invariants every cycle, scoreboard pops on mem_cs and done.
  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      chk("done_within_gnt", 32'(bus.done & ~bus.gnt), 32'd0);
      if (!bus.mem_cs) begin
        chk("mem_idle_zero", 32'({bus.mem_r_nw, bus.mem_addr, bus.mem_wdata}), 32'd0);
      end else if (ready_now) begin
        chk("mem_expected", 32'(mq.size() > 0), 32'd1);
        if (mq.size() > 0) begin
          m_got = mq.pop_front();
          chk("mem_r_nw", 32'(bus.mem_r_nw), 32'(m_got.rnw));
          chk("mem_addr", 32'(bus.mem_addr), 32'(m_got.addr));
          if (!m_got.rnw) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_got.wdata));
        end
      end
      if (bus.done != 2'b00) begin
        chk("done_expected", 32'(dq.size() > 0), 32'd1);
        if (dq.size() > 0) begin
          d_got = dq.pop_front();
          chk("done_port", 32'(bus.done), 32'(d_got.done));
          chk("rdata", 32'(bus.rdata), 32'(d_got.rdata));
        end
      end
    end
  end

  task automatic do_access(input logic port, input logic rnw, input logic [4:0] a,
                           input logic [7:0] wd, input logic [7:0] exp_rd,
                           input bit perturb, input string tag);
    int n;
    step();
    push_mem(rnw, a, wd);
    push_done(port ? 2'b10 : 2'b01, exp_rd);
    bus.r_nw[port] = rnw;
    if (port) begin bus.addr1 = a; bus.wdata1 = wd; end
    else      begin bus.addr0 = a; bus.wdata0 = wd; end
    bus.req[port] = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) begin
        chk({tag, "_cs"}, 32'(bus.mem_cs), 32'd1);
        chk({tag, "_gnt"}, 32'(bus.gnt), port ? 32'd2 : 32'd1);
        if (perturb) begin
          if (port) begin bus.addr1 = a ^ 5'h01; bus.wdata1 = ~wd; end
          else      begin bus.addr0 = a ^ 5'h01; bus.wdata0 = ~wd; end
          bus.req[port] = 1'b0;
        end
      end
    end while (bus.done == 2'b00 && n < 12);
    chk({tag, "_latency"}, 32'(n), 32'd2);
    bus.req[port] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cs_n;
    bus.req = 2'b00; bus.r_nw = 2'b00;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
`ifdef MEM_WAIT_EN
    bus.mem_ready = 1'b1;
`endif
    rst = 1'b1;
    repeat (2) step();
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_mem", 32'({bus.mem_cs, bus.mem_r_nw, bus.mem_addr, bus.mem_wdata}), 32'd0);
    rst = 1'b0;

    do_access(1'b0, 1'b1, 5'h03, 8'h00, 8'hA5, 1'b0, "p0_read");
    do_access(1'b1, 1'b0, 5'h1F, 8'h3C, 8'hA5, 1'b0, "p1_write");
    do_access(1'b0, 1'b1, 5'h1F, 8'h00, 8'h3C, 1'b0, "readback");
    do_access(1'b1, 1'b1, 5'h06, 8'h00, 8'h77, 1'b1, "mid_change");

    // Port 0 alone, four back-to-back reads with req held.
    step();
    for (int k = 0; k < 4; k++) begin
      push_mem(1'b1, 5'(16 + k), 8'h00);
      push_done(2'b01, 8'(8'hC0 + k));
    end
    bus.r_nw[0] = 1'b1; bus.addr0 = 5'd16; bus.req[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin step(); n++; end while (bus.done == 2'b00 && n < 12);
      chk("b2b_spacing", 32'(n), (k == 0) ? 32'd2 : 32'd3);
      if (k < 3) bus.addr0 = 5'(17 + k);
      else       bus.req[0] = 1'b0;
    end

    // Reset in the middle of ACCESS: abort, no done.
    step();
    push_mem(1'b1, 5'h08, 8'h00);
    bus.r_nw[0] = 1'b1; bus.addr0 = 5'h08; bus.req[0] = 1'b1;
    step();
    chk("abort_in_access", 32'(bus.mem_cs), 32'd1);
    rst = 1'b1;
    bus.req = 2'b00;
    step();
    chk("abort_gnt", 32'(bus.gnt), 32'd0);
    chk("abort_cs", 32'(bus.mem_cs), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    rst = 1'b0;

    // Both ports from reset, re-requesting: grants alternate starting at port 0.
    step();
    for (int k = 0; k < 2; k++) begin
      push_mem(1'b1, 5'h04, 8'h00); push_done(2'b01, 8'h55);
      push_mem(1'b1, 5'h05, 8'h00); push_done(2'b10, 8'h66);
    end
    bus.r_nw = 2'b11; bus.addr0 = 5'h04; bus.addr1 = 5'h05; bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin step(); n++; end while (bus.done == 2'b00 && n < 12);
      chk("alt_spacing", 32'(n), (k == 0) ? 32'd2 : 32'd3);
      if (k == 3) bus.req = 2'b00;
    end

`ifdef MEM_WAIT_EN
    // mem_ready low for three CS cycles stretches ACCESS to four cycles.
    step();
    bus.mem_ready = 1'b0;
    push_mem(1'b1, 5'h09, 8'h00);
    push_done(2'b10, 8'h99);
    bus.r_nw[1] = 1'b1; bus.addr1 = 5'h09; bus.req[1] = 1'b1;
    n = 0; cs_n = 0;
    do begin
      step();
      n++;
      if (bus.mem_cs) begin
        cs_n++;
        chk("wait_addr_stable", 32'(bus.mem_addr), 32'h09);
        if (cs_n == 3) begin
          @(posedge clk);
          #1;
          bus.mem_ready = 1'b1;
        end
      end
    end while (bus.done == 2'b00 && n < 12);
    chk("wait_cs_cycles", 32'(cs_n), 32'd4);
    chk("wait_done_cycle", 32'(n), 32'd5);
    bus.req[1] = 1'b0;
`else
    cs_n = 0;
`endif

    repeat (3) step();
    chk("sb_mem_drained", 32'(mq.size()), 32'd0);
    chk("sb_done_drained", 32'(dq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
